// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, sequencer action encoding and shadow-register
// layout for the pipeline control slice.
package riscv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // Same encoding as the hazard unit's pipeline_state bus
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_LOAD  = 2'b01,
    ST_MEMW  = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [6:0] op;
    logic [4:0] rd;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{valid: 1'b0, op: 7'd0, rd: 5'd0};

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detection: an ID instruction reading the destination of a
// load currently in EX.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic [6:0] ex_op,
  input  logic [4:0] ex_rd,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       load_use
);

  // Register-usage decode and hazard compare; x0 never creates a dependency
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    load_use = 1'b0;
    if ((id_opcode == LUI) || (id_opcode == AUIPC) || (id_opcode == JAL)) begin
      uses_rs1 = 1'b0;
    end else begin
      uses_rs1 = 1'b1;
    end
    if ((id_opcode == OP) || (id_opcode == STORE) || (id_opcode == BRANCH)) begin
      uses_rs2 = 1'b1;
    end else begin
      uses_rs2 = 1'b0;
    end
    if (ex_valid && (ex_op == LOAD) && (ex_rd != 5'd0) && id_valid) begin
      load_use = (uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd));
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: arbitrates memory wait, taken-branch flush and load-use
// bubbles, drives pipeline-register enables/flushes and counts stall cycles.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_EXTRA = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             br_taken_ex,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             stall,
  output logic [1:0]       pipeline_state,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  shadow_t          ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             uses_rs1, uses_rs2, load_use;

  load_use_detect u_load_use_detect (
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .ex_valid  (ex_q.valid),
    .ex_op     (ex_q.op),
    .ex_rd     (ex_q.rd),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .load_use  (load_use)
  );

  // Priority arbitration, next state, shadow advance and output decode
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    ex_d           = ex_q;
    mem_d          = mem_q;
    pc_en          = 1'b0;
    if_id_en       = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_en      = 1'b0;
    stall          = 1'b0;
    pipeline_state = ST_RUN;

    if (mem_wait) begin
      stall          = 1'b1;
      pipeline_state = ST_MEMW;
      state_d        = ST_MEMW;
      flush_cnt_d    = 3'd0;
    end else if (br_taken_ex || (state_q == ST_FLUSH)) begin
      // Front end refetches while the wrong-path instructions drain as bubbles
      pc_en          = 1'b1;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      ex_mem_en      = 1'b1;
      stall          = 1'b1;
      pipeline_state = ST_FLUSH;
      mem_d          = ex_q;
      ex_d           = SHADOW_BUBBLE;
      if (br_taken_ex) begin
        if (FLUSH_EXTRA > 0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 3'(FLUSH_EXTRA);
        end else begin
          state_d     = ST_RUN;
          flush_cnt_d = 3'd0;
        end
      end else if (flush_cnt_q <= 3'd1) begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end else begin
        state_d     = ST_FLUSH;
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end else if (load_use) begin
      id_ex_flush    = 1'b1;
      ex_mem_en      = 1'b1;
      stall          = 1'b1;
      pipeline_state = ST_LOAD;
      state_d        = ST_LOAD;
      mem_d          = ex_q;
      ex_d           = SHADOW_BUBBLE;
    end else begin
      pc_en          = 1'b1;
      if_id_en       = 1'b1;
      ex_mem_en      = 1'b1;
      state_d        = ST_RUN;
      mem_d          = ex_q;
      ex_d           = '{valid: id_valid, op: id_opcode, rd: id_rd};
    end

    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    // Hold the pipeline frozen and cleared for as long as reset is low
    if (!rst_n) begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      ex_mem_en      = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      stall          = 1'b0;
      pipeline_state = ST_RUN;
    end else begin
      pipeline_state = pipeline_state;
    end
  end

  // State, flush counter, shadows and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      ex_q        <= SHADOW_BUBBLE;
      mem_q       <= SHADOW_BUBBLE;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule
